dcache_flush_engine: RTL
========================

// Module: dcache_flush_engine
// PURPOSE
//  Hardware write-back/flush sequencer for the direct-mapped data cache. On request it
//  walks every cache line, writes dirty valid lines to Data_Memory over the existing
//  enable/write/ack handshake, then cleans or invalidates each line. Sits between the
//  dcache tag/data SRAMs and the memory port, muxed with the dcache controller. CPU
//  stalls on busy_o. Replaces the bench-only backdoor flush.
// PARAMETERS
//  NUM_LINES    32   cache lines, power of 2 (IDX_W = log2(NUM_LINES))
//  LINE_BITS    256  bits per line
//  TAG_BITS     22   address tag bits; tag SRAM entry = {valid, dirty, tag} = TAG_BITS+2
//  OFFSET_BITS  5    byte-offset bits per line
//  ADDR_BITS    32   memory address width; TAG_BITS+IDX_W+OFFSET_BITS <= ADDR_BITS
// PORTS
//  clk_i          in   1              clock
//  rst_i          in   1              async reset, active-low
//  flush_i        in   1              start request (level, sampled in IDLE only)
//  mode_i         in   1              0 = clean (keep valid), 1 = clean+invalidate; latched at start
//  busy_o         out  1              engine active (IDLE -> 0)
//  done_o         out  1              one-cycle pulse at end of walk
//  wb_cnt_o       out  IDX_W+1        lines written back in the last/current walk
//  sram_addr_o    out  IDX_W          SRAM line index
//  sram_tag_i     in   TAG_BITS+2     tag entry, valid 1 cycle after sram_addr_o
//  sram_data_i    in   LINE_BITS      line data, same timing as sram_tag_i
//  sram_we_o      out  1              tag SRAM write enable
//  sram_tag_o     out  TAG_BITS+2     tag entry to write
//  mem_enable_o   out  1              memory request
//  mem_write_o    out  1              memory write
//  mem_addr_o     out  ADDR_BITS      memory byte address
//  mem_data_o     out  LINE_BITS      memory write data
//  mem_ack_i      in   1              memory completion
// BEHAVIOUR
//  Reset: state IDLE; busy_o, done_o, sram_we_o, mem_enable_o, mem_write_o = 0;
//   sram_addr_o, mem_addr_o, mem_data_o, sram_tag_o, wb_cnt_o = 0. Async assertion
//   mid-walk aborts immediately; no further SRAM or memory writes issued.
//  States: IDLE, RD, CHK, WB, UPD, DONE.
//  IDLE: flush_i=1 -> latch mode_i, idx=0, wb_cnt_o=0, -> RD. busy_o=1 from RD onward.
//  RD: sram_addr_o=idx -> CHK (1-cycle SRAM read latency).
//  CHK: entry {v,d,tag}. v&d -> capture mem_addr_o={0..,tag,idx,OFFSET_BITS'b0},
//   mem_data_o=sram_data_i -> WB. v&~d&mode=1 -> UPD. else -> advance.
//  WB: mem_enable_o=mem_write_o=1; addr/data held stable until the cycle mem_ack_i=1;
//   then deassert both, wb_cnt_o+1 -> UPD. No timeout; waits indefinitely.
//  UPD: sram_we_o=1 for exactly one cycle; sram_tag_o = mode 0 ? {1,0,tag} : {0,0,tag}
//   -> advance.
//  advance: idx==NUM_LINES-1 -> DONE; else idx+1 -> RD. No wrap past last line.
//  DONE: done_o=1 one cycle, busy_o=0 -> IDLE. flush_i still high re-starts from IDLE
//   next cycle (new walk, wb_cnt_o cleared).
//  Timing: clean/invalid line = 2 cycles; invalidated clean line = 3; dirty line =
//   3 + ack wait + 1 (UPD). Empty walk = 2*NUM_LINES + 1 cycles start to done.
//  flush_i and mode_i ignored outside IDLE. mem_ack_i ignored outside WB.
//  wb_cnt_o holds its value after DONE until next start.
// TESTING
//  1 All entries 0, flush_i pulse -> no mem_enable_o, done_o after 65 cycles, wb_cnt_o=0.
//  2 Line 3 = {1,1,22'h1}, data 256'hA5..A5, ack 10 cycles later -> mem_addr_o=32'h460,
//    data stable until ack, then sram_tag_o={1,0,22'h1} at idx 3, wb_cnt_o=1.
//  3 mode_i=1, line 7 = {1,0,22'h3} -> no memory access, sram_we_o at idx 7 with {0,0,22'h3}.
//  4 flush_i pulsed again while busy -> ignored, wb_cnt_o unchanged, single done_o pulse.
//  5 rst_i low during WB -> mem_enable_o/busy_o drop asynchronously, no sram_we_o after.
//  6 NUM_LINES=8, LINE_BITS=128, all dirty, ack in 1 cycle -> 8 writes, addresses
//    in index order, wb_cnt_o=8.

Source files
------------

// File: rtl/dcache_flush_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dcache_flush_engine : walks every dcache line, writes back dirty lines, then
// cleans or invalidates them.                                      Rev 1.0
// ----------------------------------------------------------------------------
module dcache_flush_engine #(
  parameter int NUM_LINES   = 32,
  parameter int LINE_BITS   = 256,
  parameter int TAG_BITS    = 22,
  parameter int OFFSET_BITS = 5,
  parameter int ADDR_BITS   = 32,
  localparam int IDX_W      = $clog2(NUM_LINES),
  localparam int ENT_W      = TAG_BITS + 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 mode_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IDX_W:0]       wb_cnt_o,
  output logic [IDX_W-1:0]     sram_addr_o,
  input  logic [ENT_W-1:0]     sram_tag_i,
  input  logic [LINE_BITS-1:0] sram_data_i,
  output logic                 sram_we_o,
  output logic [ENT_W-1:0]     sram_tag_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic                 mem_ack_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CHK  = 3'd2,
    WB   = 3'd3,
    UPD  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [IDX_W-1:0]     idx;
  logic                 mode;
  logic                 line_v;
  logic                 line_d;
  logic [TAG_BITS-1:0]  line_tag;
  logic                 last;
  logic                 needs_upd;
  logic [ADDR_BITS-1:0] wb_addr;

  assign line_v      = sram_tag_i[ENT_W-1];
  assign line_d      = sram_tag_i[ENT_W-2];
  assign line_tag    = sram_tag_i[TAG_BITS-1:0];
  assign last        = (idx == IDX_W'(NUM_LINES - 1));
  // A valid line gets a tag rewrite if it is dirty or is being invalidated.
  assign needs_upd   = line_v & (line_d | mode);
  assign sram_addr_o = idx;

  always_comb begin
    wb_addr = '0;
    wb_addr[OFFSET_BITS +: IDX_W]             = idx;
    wb_addr[OFFSET_BITS + IDX_W +: TAG_BITS]  = line_tag;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      mode       <= 1'b0;
      wb_cnt_o   <= '0;
      sram_tag_o <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (flush_i) begin
            mode     <= mode_i;
            idx      <= '0;
            wb_cnt_o <= '0;
          end
        end
        CHK: begin
          if (needs_upd) sram_tag_o <= {~mode, 1'b0, line_tag};
          if (line_v & line_d) begin
            mem_addr_o <= wb_addr;
            mem_data_o <= sram_data_i;
          end
          if (!needs_upd && !last) idx <= idx + 1'b1;
        end
        WB: begin
          if (mem_ack_i) wb_cnt_o <= wb_cnt_o + 1'b1;
        end
        UPD: begin
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    sram_we_o    = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    case (state)
      IDLE: begin
        if (flush_i) state_nx = RD;
      end
      RD: begin
        busy_o   = 1'b1;
        state_nx = CHK;
      end
      CHK: begin
        busy_o = 1'b1;
        if (line_v & line_d) state_nx = WB;
        else if (needs_upd)  state_nx = UPD;
        else                 state_nx = last ? DONE : RD;
      end
      WB: begin
        busy_o       = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        if (mem_ack_i) state_nx = UPD;
      end
      UPD: begin
        busy_o    = 1'b1;
        sram_we_o = 1'b1;
        state_nx  = last ? DONE : RD;
      end
      DONE: begin
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire
